// File: rtl/toy_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// toy_wb_arbiter_pkg
//
// Shared types and constants for the write-back arbiter that sits between
// the execution units' commit outputs and the integer register file.
//
// Contents:
//   REG_WIDTH, INST_IDX_WIDTH   - widths of the result value and the
//                                 scoreboard instruction tag
//   WB_NUM_REQ, WB_NUM_WP       - default requester / write-port counts
//   WB_FIFO_DEPTH               - default per-requester queue depth
//   wb_req_t                    - one write-back result
//   wb_src_e                    - requester ids (LSU, ALU, MEXT, CSR)
//   wb_waw_hit()                - two results target the same real register
//   wb_commit_wr_en()           - regfile write enable for a committed result
// ---------------------------------------------------------------------------
package toy_wb_arbiter_pkg;

  localparam int REG_WIDTH      = 32;
  localparam int INST_IDX_WIDTH = 6;

  localparam int WB_NUM_REQ    = 4;
  localparam int WB_NUM_WP     = 2;
  localparam int WB_FIFO_DEPTH = 2;

  // One result travelling from an execution unit to the register file.
  typedef struct packed {
    logic [4:0]                index;
    logic                      wr_en;
    logic [REG_WIDTH-1:0]      val;
    logic [INST_IDX_WIDTH-1:0] inst_idx;
  } wb_req_t;

  // Requester ids; the position of a requester in req_* matches these.
  typedef enum logic [1:0] {
    WB_SRC_LSU  = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_MEXT = 2'd2,
    WB_SRC_CSR  = 2'd3
  } wb_src_e;

  // Two results collide when both really write the same architectural
  // register. Writes to x0 never collide because they are discarded.
  function automatic logic wb_waw_hit(input wb_req_t a, input wb_req_t b);
    return a.wr_en && b.wr_en && (a.index == b.index) && (a.index != 5'd0);
  endfunction

  // A result still commits when it targets x0, but the regfile must not
  // be written.
  function automatic logic wb_commit_wr_en(input wb_req_t e);
    return e.wr_en && (e.index != 5'd0);
  endfunction

endpackage

// File: rtl/toy_wb_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// toy_wb_fifo
//
// Small in-order queue holding write-back results for one requester.
// Count, pointers and storage are all registered; the head entry is read
// straight from storage so the arbiter sees it in the cycle after a push.
//
// Parameters:
//   DEPTH      entries, power of two, >= 2
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, empties the queue
//   flush      empties the queue at the next edge (wins over push/pop)
//   push       write push_data at the tail (ignored when full)
//   pop        drop the head entry (ignored when empty)
//   push_data  entry to enqueue
//   full       queue holds DEPTH entries
//   empty      queue holds no entries
//   head       oldest entry; only meaningful when !empty
//   count      number of entries held
// ---------------------------------------------------------------------------
module toy_wb_fifo
  import toy_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  wb_req_t       push_data,
  output logic          full,
  output logic          empty,
  output wb_req_t       head,
  output logic [CW-1:0] count
);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Guard against pushing into a full queue or popping an empty one so
  // that the count can never wrap, whatever the caller does.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers and count. DEPTH is a power of two, so the pointers wrap
  // naturally at their width. Flush and reset share the same clear path.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only ever read after it has been
  // written, because empty gates every consumer of head.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/toy_wb_arbiter.sv
// ---------------------------------------------------------------------------
// toy_wb_arbiter
//
// Shares NUM_WP register-file write ports among NUM_REQ execution units.
// Each unit owns a small FIFO behind a valid/ready handshake. Every cycle
// the non-empty FIFO heads are scanned round-robin starting at rr_ptr and
// up to NUM_WP of them are granted, one per requester, in scan order onto
// ports 0, 1, ... . Granted heads pop in the same cycle and the winners are
// presented one cycle later on registered wp_* outputs.
//
// Parameters:
//   NUM_REQ     requesters (0=LSU, 1=ALU, 2=MEXT, 3=CSR), >= 2
//   NUM_WP      write ports, 1..NUM_REQ
//   FIFO_DEPTH  entries per requester FIFO, power of two, >= 2
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   flush       pipeline kill: empty all FIFOs, drop pushes, no grants
//   hold        regfile busy: no grants and no pops this cycle
//   req_vld     per-requester result valid
//   req_rdy     per-requester FIFO can accept
//   req_data    per-requester result
//   wp_vld      write-port slot carries a commit
//   wp_wr_en    regfile write enable (suppressed for x0)
//   wp_data     committed entry (zero when the slot is idle)
//   wp_src      requester id that owns the slot
//   occupancy   per-FIFO entry count
// ---------------------------------------------------------------------------
module toy_wb_arbiter
  import toy_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = WB_NUM_REQ,
  parameter int NUM_WP     = WB_NUM_WP,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  localparam int SRC_W     = $clog2(NUM_REQ),
  localparam int OCC_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             hold,
  input  logic [NUM_REQ-1:0]               req_vld,
  output logic [NUM_REQ-1:0]               req_rdy,
  input  wb_req_t [NUM_REQ-1:0]            req_data,
  output logic [NUM_WP-1:0]                wp_vld,
  output logic [NUM_WP-1:0]                wp_wr_en,
  output wb_req_t [NUM_WP-1:0]             wp_data,
  output logic [NUM_WP-1:0][SRC_W-1:0]     wp_src,
  output logic [NUM_REQ-1:0][OCC_W-1:0]    occupancy
);

  // -------------------------------------------------------------------------
  // Per-requester FIFOs
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] fifo_full;
  logic [NUM_REQ-1:0] fifo_empty;
  logic [NUM_REQ-1:0] fifo_push;
  logic [NUM_REQ-1:0] fifo_pop;
  wb_req_t            fifo_head [NUM_REQ];

  // Ready comes from the count before this cycle's pop, so a full FIFO
  // only reopens the cycle after it drains. Flush and reset close every
  // door so nothing sneaks in while the queues are being cleared.
  assign req_rdy   = ~fifo_full & {NUM_REQ{!flush && !rst}};
  assign fifo_push = req_vld & req_rdy;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_fifo
    toy_wb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (fifo_push[r]),
      .pop       (fifo_pop[r]),
      .push_data (req_data[r]),
      .full      (fifo_full[r]),
      .empty     (fifo_empty[r]),
      .head      (fifo_head[r]),
      .count     (occupancy[r])
    );
  end

  // -------------------------------------------------------------------------
  // Round-robin scan with WAW guard
  // -------------------------------------------------------------------------
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  rr_next;
  logic              arb_enable;
  logic [SRC_W-1:0]  scan_id [NUM_REQ];
  logic [NUM_REQ-1:0] scan_elig;
  logic [NUM_REQ-1:0] grant_mask;
  logic [NUM_WP-1:0] slot_vld;
  logic [SRC_W-1:0]  slot_src  [NUM_WP];
  wb_req_t           slot_data [NUM_WP];
  int                rank;

  assign arb_enable = !hold && !flush && !rst;
  assign fifo_pop   = grant_mask;

  // Position off in the scan visits requester (rr_ptr + off) mod NUM_REQ.
  always_comb begin
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_id[off] = SRC_W'((int'(rr_ptr) + off) % NUM_REQ);
    end
  end

  // A head is eligible when it exists and no earlier head in scan order
  // writes the same real register. Comparing against every earlier head
  // (not just the winners) gives the same answer: a head that lost to a
  // WAW clash shares its index with an earlier winner, and a head that
  // lost for lack of ports makes everything after it lose too.
  always_comb begin
    scan_elig = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_elig[off] = arb_enable && !fifo_empty[scan_id[off]];
      for (int prev = 0; prev < off; prev++) begin
        if (!fifo_empty[scan_id[prev]] &&
            wb_waw_hit(fifo_head[scan_id[prev]], fifo_head[scan_id[off]])) begin
          scan_elig[off] = 1'b0;
        end
      end
    end
  end

  // Hand out ports in scan order: the k-th eligible head lands on port k.
  // The pointer follows the last winner so the next scan starts just past
  // it; with no winner it stays where it was.
  always_comb begin
    rank       = 0;
    grant_mask = '0;
    slot_vld   = '0;
    rr_next    = rr_ptr;
    for (int k = 0; k < NUM_WP; k++) begin
      slot_src[k]  = '0;
      slot_data[k] = '0;
    end
    for (int off = 0; off < NUM_REQ; off++) begin
      if (scan_elig[off]) begin
        for (int k = 0; k < NUM_WP; k++) begin
          if (rank == k) begin
            slot_vld[k]  = 1'b1;
            slot_src[k]  = scan_id[off];
            slot_data[k] = fifo_head[scan_id[off]];
          end
        end
        if (rank < NUM_WP) begin
          grant_mask[scan_id[off]] = 1'b1;
          rr_next = SRC_W'((int'(scan_id[off]) + 1) % NUM_REQ);
        end
        rank = rank + 1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output registers and round-robin pointer
  // -------------------------------------------------------------------------

  // Every grant shows up for exactly one cycle; idle slots are driven to
  // zero so downstream logic never sees stale data on an idle port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      wp_vld   <= '0;
      wp_wr_en <= '0;
      wp_data  <= '0;
      wp_src   <= '0;
    end else begin
      rr_ptr <= rr_next;
      wp_vld <= slot_vld;
      for (int k = 0; k < NUM_WP; k++) begin
        wp_wr_en[k] <= slot_vld[k] && wb_commit_wr_en(slot_data[k]);
        wp_data[k]  <= slot_vld[k] ? slot_data[k] : '0;
        wp_src[k]   <= slot_src[k];
      end
    end
  end

endmodule

// File: tb/tb_toy_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_toy_wb_arbiter
//
// Drives the write-back arbiter with directed scenarios followed by random
// traffic and compares every output, every cycle, against a queue-level
// model of the arbitration rules. A few hand-computed expectations pin the
// model in the directed scenarios.
// ---------------------------------------------------------------------------
module tb_toy_wb_arbiter;
  import toy_wb_arbiter_pkg::*;

  localparam int NR  = 4;
  localparam int NW  = 2;
  localparam int DEP = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   hold;
  logic [NR-1:0]          req_vld;
  logic [NR-1:0]          req_rdy;
  wb_req_t [NR-1:0]       req_data;
  logic [NW-1:0]          wp_vld;
  logic [NW-1:0]          wp_wr_en;
  wb_req_t [NW-1:0]       wp_data;
  logic [NW-1:0][1:0]     wp_src;
  logic [NR-1:0][1:0]     occupancy;

  int total = 0;
  int bad   = 0;

  // Model state: contents of each queue, the scan start, and what the
  // write ports must show after the next edge.
  wb_req_t       mq   [NR][DEP];
  int            mcnt [NR];
  int            m_rr;
  logic [NW-1:0] e_vld;
  logic [NW-1:0] e_wr;
  wb_req_t       e_data [NW];
  int            e_src  [NW];

  always #5 clk = ~clk;

  toy_wb_arbiter #(
    .NUM_REQ    (NR),
    .NUM_WP     (NW),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .hold      (hold),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_data  (req_data),
    .wp_vld    (wp_vld),
    .wp_wr_en  (wp_wr_en),
    .wp_data   (wp_data),
    .wp_src    (wp_src),
    .occupancy (occupancy)
  );

  task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    m_rr  = 0;
    e_vld = '0;
    e_wr  = '0;
    for (int k = 0; k < NW; k++) begin
      e_data[k] = '0;
      e_src[k]  = 0;
    end
  endtask

  function automatic logic modelRdy(input int r);
    return !rst && !flush && (mcnt[r] < DEP);
  endfunction

  // One clock edge of the arbitration rules, applied to the model queues.
  task automatic modelStep();
    logic [NR-1:0] accept;
    int            gid [NW];
    int            ng;
    int            id;
    logic          clash;
    wb_req_t       h;
    wb_req_t       g;
    if (rst) begin
      modelReset();
      return;
    end
    for (int r = 0; r < NR; r++) accept[r] = req_vld[r] && modelRdy(r);
    ng    = 0;
    e_vld = '0;
    e_wr  = '0;
    for (int k = 0; k < NW; k++) begin
      e_data[k] = '0;
      e_src[k]  = 0;
      gid[k]    = 0;
    end
    if (!hold && !flush) begin
      for (int off = 0; off < NR; off++) begin
        id = (m_rr + off) % NR;
        if (mcnt[id] > 0 && ng < NW) begin
          h = mq[id][0];
          clash = 1'b0;
          for (int j = 0; j < ng; j++) begin
            g = mq[gid[j]][0];
            if (g.wr_en && h.wr_en && g.index == h.index && h.index != 5'd0) clash = 1'b1;
          end
          if (!clash) begin
            gid[ng]    = id;
            e_vld[ng]  = 1'b1;
            e_wr[ng]   = h.wr_en && (h.index != 5'd0);
            e_data[ng] = h;
            e_src[ng]  = id;
            ng++;
          end
        end
      end
    end
    if (ng > 0) m_rr = (gid[ng-1] + 1) % NR;
    for (int j = 0; j < ng; j++) begin
      for (int s = 0; s < DEP - 1; s++) mq[gid[j]][s] = mq[gid[j]][s+1];
      mcnt[gid[j]]--;
    end
    if (flush) begin
      for (int r = 0; r < NR; r++) mcnt[r] = 0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (accept[r]) begin
          mq[r][mcnt[r]] = req_data[r];
          mcnt[r]++;
        end
      end
    end
  endtask

  // Compare the registered outputs and occupancy against the model.
  task automatic checkOutput();
    for (int k = 0; k < NW; k++) begin
      checkVal($sformatf("wp_vld[%0d]", k), 64'(wp_vld[k]), 64'(e_vld[k]));
      checkVal($sformatf("wp_wr_en[%0d]", k), 64'(wp_wr_en[k]), 64'(e_wr[k]));
      if (e_vld[k]) begin
        checkVal($sformatf("wp_data[%0d]", k), 64'(wp_data[k]), 64'(e_data[k]));
        checkVal($sformatf("wp_src[%0d]", k), 64'(wp_src[k]), 64'(e_src[k]));
      end
    end
    for (int r = 0; r < NR; r++) begin
      checkVal($sformatf("occupancy[%0d]", r), 64'(occupancy[r]), 64'(mcnt[r]));
    end
  endtask

  // Called at a falling edge: check, drive, step the model, advance a cycle.
  task automatic applyStimulus(input logic rst_i, input logic flush_i, input logic hold_i,
                               input logic [NR-1:0] vld_i, input wb_req_t [NR-1:0] d_i);
    checkOutput();
    rst      = rst_i;
    flush    = flush_i;
    hold     = hold_i;
    req_vld  = vld_i;
    req_data = d_i;
    #1;
    for (int r = 0; r < NR; r++) begin
      checkVal($sformatf("req_rdy[%0d]", r), 64'(req_rdy[r]), 64'(modelRdy(r)));
    end
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic wb_req_t mkReq(input int idx, input logic we, input logic [31:0] v, input int tag);
    wb_req_t e;
    e.index    = 5'(idx);
    e.wr_en    = we;
    e.val      = v;
    e.inst_idx = 6'(tag);
    return e;
  endfunction

  wb_req_t [NR-1:0] d;
  wb_req_t [NR-1:0] none;

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    hold     = 1'b0;
    req_vld  = '0;
    req_data = '0;
    none     = '0;
    modelReset();
    @(posedge clk);
    @(negedge clk);

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, '0, none);
    checkVal("reset_rdy", 64'(req_rdy), 64'(0));
    checkVal("reset_vld", 64'(wp_vld), 64'(0));
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, none);
    checkVal("rdy_after_reset", 64'(req_rdy), 64'hF);

    // Single ALU request, two-cycle latency, one-cycle pulse
    $display("[TB] single request");
    d = '0;
    d[1] = mkReq(5, 1'b1, 32'hDEAD_BEEF, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, d);
    checkVal("single_early", 64'(wp_vld), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, none);
    checkVal("single_vld", 64'(wp_vld), 64'b01);
    checkVal("single_wr", 64'(wp_wr_en), 64'b01);
    checkVal("single_src", 64'(wp_src[0]), 64'd1);
    checkVal("single_val", 64'(wp_data[0].val), 64'hDEAD_BEEF);
    checkVal("single_idx", 64'(wp_data[0].index), 64'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, none);
    checkVal("single_pulse", 64'(wp_vld), 64'(0));

    // WAW: LSU and MEXT both write x7, scan from requester 0
    $display("[TB] waw");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, none);
    d = '0;
    d[0] = mkReq(7, 1'b1, 32'h11, 2);
    d[2] = mkReq(7, 1'b1, 32'h22, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0101, d);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, none);
    checkVal("waw_first_vld", 64'(wp_vld), 64'b01);
    checkVal("waw_first_src", 64'(wp_src[0]), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, none);
    checkVal("waw_second_vld", 64'(wp_vld), 64'b01);
    checkVal("waw_second_src", 64'(wp_src[0]), 64'd2);
    checkVal("waw_second_val", 64'(wp_data[0].val), 64'h22);

    // x0 write commits without a regfile write
    $display("[TB] x0");
    d = '0;
    d[3] = mkReq(0, 1'b1, 32'h33, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1000, d);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, none);
    checkVal("x0_vld", 64'(wp_vld), 64'b01);
    checkVal("x0_wr", 64'(wp_wr_en), 64'b00);
    checkVal("x0_src", 64'(wp_src[0]), 64'd3);

    // Hold for three cycles with ALU entries queued
    $display("[TB] hold");
    d = '0;
    d[1] = mkReq(9, 1'b1, 32'hA0, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010, d);
    checkVal("hold_vld_1", 64'(wp_vld), 64'(0));
    d[1] = mkReq(10, 1'b1, 32'hB0, 6);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010, d);
    checkVal("hold_vld_2", 64'(wp_vld), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b1, '0, none);
    checkVal("hold_vld_3", 64'(wp_vld), 64'(0));
    checkVal("hold_occ", 64'(occupancy[1]), 64'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, none);
    checkVal("drain_a", 64'(wp_data[0].val), 64'hA0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, none);
    checkVal("drain_b", 64'(wp_data[0].val), 64'hB0);

    // Round robin with all four requesters pushing every cycle
    $display("[TB] round robin");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, none);
    for (int c = 0; c < 12; c++) begin
      for (int r = 0; r < NR; r++) d[r] = mkReq(r + 8, 1'b1, 32'(c * 16 + r), c);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, d);
      if (c == 1) begin
        checkVal("rr_a_vld", 64'(wp_vld), 64'b11);
        checkVal("rr_a_src0", 64'(wp_src[0]), 64'd0);
        checkVal("rr_a_src1", 64'(wp_src[1]), 64'd1);
      end
      if (c == 2) begin
        checkVal("rr_b_src0", 64'(wp_src[0]), 64'd2);
        checkVal("rr_b_src1", 64'(wp_src[1]), 64'd3);
      end
    end

    // Fill, then flush together with a push
    $display("[TB] flush");
    applyStimulus(1'b0, 1'b1, 1'b0, '0, none);
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < NR; r++) d[r] = mkReq(r + 16, 1'b1, 32'(100 + c * 4 + r), c);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, d);
    end
    for (int r = 0; r < NR; r++) checkVal($sformatf("fill_occ[%0d]", r), 64'(occupancy[r]), 64'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, d);
    for (int r = 0; r < NR; r++) checkVal($sformatf("flush_occ[%0d]", r), 64'(occupancy[r]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, none);
      checkVal("flush_quiet", 64'(wp_vld), 64'(0));
    end

    // Fill, then reset together with a push
    $display("[TB] mid-operation reset");
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < NR; r++) d[r] = mkReq(r + 20, 1'b1, 32'(200 + c * 4 + r), c);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, d);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, d);
    checkVal("rst_rdy", 64'(req_rdy), 64'(0));
    checkVal("rst_vld", 64'(wp_vld), 64'(0));
    checkVal("rst_data", 64'(wp_data[0]), 64'(0));
    checkVal("rst_occ", 64'(occupancy), 64'(0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, none);

    // Random traffic
    $display("[TB] random");
    for (int c = 0; c < 3000; c++) begin
      logic rr_i, fl_i, ho_i;
      for (int r = 0; r < NR; r++) begin
        d[r] = mkReq($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 63));
      end
      rr_i = ($urandom_range(0, 63) == 0);
      fl_i = ($urandom_range(0, 19) == 0);
      ho_i = ($urandom_range(0, 4) == 0);
      applyStimulus(rr_i, fl_i, ho_i, 4'($urandom_range(0, 15)), d);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, none);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
